regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Write-port arbiter for a single-write-port register file. It queues the
//   dual write-back requests (dstE/valE, dstM/valM) in a small FIFO and drains
//   one write per cycle. It also flags decode reads that hit a pending write.
//
// Optional feature (macro RF_ARB_FWD_EN):
//   When defined, adds fwdA_valid/fwdA_val and fwdB_valid/fwdB_val. These carry
//   the value of the youngest queued write that matches srcA/srcB.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   wb_valid, wb_ready   write-back request handshake
//   dstE/valE, dstM/valM E and M write-back ports (RNONE = no write)
//   rf_we/rf_dst/rf_val  register-file write port, driven from the FIFO head
//   srcA, srcB           decode read addresses
//   srcA_busy/srcB_busy  read address matches an occupied FIFO entry
//   count, full, empty   FIFO occupancy
module regfile_wr_arbiter #(
   parameter int         DEPTH = 4,
   parameter logic [3:0] RNONE = 4'hF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid,
   output logic                     wb_ready,
   input  logic [3:0]               dstE,
   input  logic [63:0]              valE,
   input  logic [3:0]               dstM,
   input  logic [63:0]              valM,
   output logic                     rf_we,
   output logic [3:0]               rf_dst,
   output logic [63:0]              rf_val,
   input  logic [3:0]               srcA,
   input  logic [3:0]               srcB,
   output logic                     srcA_busy,
   output logic                     srcB_busy,
`ifdef RF_ARB_FWD_EN
   output logic                     fwdA_valid,
   output logic [63:0]              fwdA_val,
   output logic                     fwdB_valid,
   output logic [63:0]              fwdB_val,
`endif
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [3:0]    mem_dst [DEPTH];
   logic [63:0]   mem_val [DEPTH];
   logic [PW-1:0] head, tail, tail_p1;
   logic          accept, push_e, push_m, pop;
   logic [CW-1:0] npush;
   logic [DEPTH-1:0] occ, hit_a, hit_b;

   // Readiness only looks at the current count, so it does not depend on this
   // cycle's pop. Two free slots always cover the worst-case two pushes.
   assign wb_ready = (CW'(DEPTH) - count) >= CW'(2);
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);

   assign accept  = wb_valid && wb_ready;
   assign push_m  = accept && (dstM != RNONE);
   // When both ports target the same register, M wins (e.g. popq %rsp).
   // Only the M entry is kept.
   assign push_e  = accept && (dstE != RNONE) && (dstE != dstM);
   assign npush   = CW'(push_e) + CW'(push_m);
   assign pop     = !empty;
   assign tail_p1 = tail + PW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(pop);
         tail  <= tail + PW'(npush);
         count <= count + npush - CW'(pop);
      end
   end

   // Storage needs no reset. Only entries covered by count are ever observed.
   always_ff @(posedge clk) begin
      if (push_e) begin
         mem_dst[tail] <= dstE;
         mem_val[tail] <= valE;
      end
      if (push_m) begin
         mem_dst[push_e ? tail_p1 : tail] <= dstM;
         mem_val[push_e ? tail_p1 : tail] <= valM;
      end
   end

   assign rf_we  = !empty;
   assign rf_dst = empty ? RNONE : mem_dst[head];
   assign rf_val = empty ? 64'd0 : mem_val[head];

   // An entry is occupied when its distance from head is below count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic [PW-1:0] off;
      assign off      = PW'(i) - head;
      assign occ[i]   = CW'(off) < count;
      assign hit_a[i] = occ[i] && (mem_dst[i] == srcA);
      assign hit_b[i] = occ[i] && (mem_dst[i] == srcB);
   end

   assign srcA_busy = (srcA != RNONE) && (|hit_a);
   assign srcB_busy = (srcB != RNONE) && (|hit_b);

`ifdef RF_ARB_FWD_EN
   assign fwdA_valid = srcA_busy;
   assign fwdB_valid = srcB_busy;

   // Walk the entries from oldest to youngest. A later match overrides an
   // earlier one, so the value closest to tail wins.
   always_comb begin
      fwdA_val = '0;
      fwdB_val = '0;
      for (int k = 0; k < DEPTH; k++) begin
         logic [PW-1:0] idx;
         idx = head + PW'(k);
         if ((CW'(k) < count) && (mem_dst[idx] == srcA)) fwdA_val = mem_val[idx];
         if ((CW'(k) < count) && (mem_dst[idx] == srcB)) fwdB_val = mem_val[idx];
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (DEPTH=4, RNONE=F).
module tb_regfile_wr_arbiter;
   logic        clk, rst, wb_valid, wb_ready;
   logic [3:0]  dstE, dstM, srcA, srcB, rf_dst;
   logic [63:0] valE, valM, rf_val;
   logic        rf_we, srcA_busy, srcB_busy, full, empty;
   logic [2:0]  count;
`ifdef RF_ARB_FWD_EN
   logic        fwdA_valid, fwdB_valid;
   logic [63:0] fwdA_val, fwdB_val;
`endif

   int chk_cnt = 0;
   int pass_cnt = 0;

   regfile_wr_arbiter #(.DEPTH(4), .RNONE(4'hF)) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
      .rf_we(rf_we), .rf_dst(rf_dst), .rf_val(rf_val),
      .srcA(srcA), .srcB(srcB), .srcA_busy(srcA_busy), .srcB_busy(srcB_busy),
`ifdef RF_ARB_FWD_EN
      .fwdA_valid(fwdA_valid), .fwdA_val(fwdA_val),
      .fwdB_valid(fwdB_valid), .fwdB_val(fwdB_val),
`endif
      .count(count), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Present one request across the next posedge, then withdraw it.
   task automatic req(input logic [3:0] e, input logic [63:0] ve,
                      input logic [3:0] m, input logic [63:0] vm);
      wb_valid = 1'b1; dstE = e; valE = ve; dstM = m; valM = vm;
      @(posedge clk); #1;
      wb_valid = 1'b0; dstE = 4'hF; dstM = 4'hF;
   endtask

   initial begin
      int  i, w;
      bit  acc, saw_stall, wrote;
      logic [3:0]  edst;
      logic [63:0] eval;

      rst = 1'b1; wb_valid = 1'b0; dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
      srcA = 4'hF; srcB = 4'hF;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst count", count, 0);
      chk("rst empty", empty, 1);
      chk("rst full", full, 0);
      chk("rst ready", wb_ready, 1);
      chk("rst rf_we", rf_we, 0);
      chk("rst rf_dst", rf_dst, 4'hF);
      chk("rst rf_val", rf_val, 0);
      chk("rst busy", {srcA_busy, srcB_busy}, 0);

      // Single E write
      req(4'd3, 64'h11, 4'hF, 64'h0);
      @(negedge clk);
      chk("t1 count", count, 1);
      chk("t1 rf_we", rf_we, 1);
      chk("t1 rf_dst", rf_dst, 3);
      chk("t1 rf_val", rf_val, 64'h11);
      @(negedge clk);
      chk("t1 empty", empty, 1);
      chk("t1 rf_we off", rf_we, 0);

      // E then M, with busy tracking
      srcA = 4'd5; srcB = 4'd2;
      req(4'd2, 64'hA, 4'd5, 64'hB);
      @(negedge clk);
      chk("t2 count", count, 2);
      chk("t2 w0 dst", rf_dst, 2);
      chk("t2 w0 val", rf_val, 64'hA);
      chk("t2 A busy0", srcA_busy, 1);
      chk("t2 B busy0", srcB_busy, 1);
      @(negedge clk);
      chk("t2 w1 we", rf_we, 1);
      chk("t2 w1 dst", rf_dst, 5);
      chk("t2 w1 val", rf_val, 64'hB);
      chk("t2 A busy1", srcA_busy, 1);
      chk("t2 B busy1", srcB_busy, 0);
      @(negedge clk);
      chk("t2 empty", empty, 1);
      chk("t2 A busy2", srcA_busy, 0);
      srcA = 4'hF; srcB = 4'hF;

      // Same destination: only M is written
      req(4'd4, 64'h100, 4'd4, 64'h200);
      @(negedge clk);
      chk("t3 count", count, 1);
      chk("t3 rf_dst", rf_dst, 4);
      chk("t3 rf_val", rf_val, 64'h200);
      @(negedge clk);
      chk("t3 empty", empty, 1);

      // Back-to-back two-entry requests. Order must be preserved under backpressure.
      @(posedge clk); #1;
      i = 0; w = 0; saw_stall = 0;
      for (int cyc = 0; cyc < 100 && !(i == 8 && w == 16); cyc++) begin
         if (i < 8) begin
            wb_valid = 1'b1;
            dstE = 4'((2 * i) % 14);     valE = 64'(i * 16 + 1);
            dstM = 4'((2 * i) % 14 + 1); valM = 64'(i * 16 + 2);
         end else begin
            wb_valid = 1'b0; dstE = 4'hF; dstM = 4'hF;
         end
         @(negedge clk);
         if (rf_we) begin
            edst = 4'((2 * (w / 2)) % 14 + (w % 2));
            eval = 64'((w / 2) * 16 + 1 + (w % 2));
            chk($sformatf("stream dst %0d", w), rf_dst, edst);
            chk($sformatf("stream val %0d", w), rf_val, eval);
            w++;
         end
         if (count == 3'd3) begin
            chk("stream ready@3", wb_ready, 0);
            saw_stall = 1;
         end
         chk("stream not full", full, 0);
         acc = wb_valid && wb_ready;
         @(posedge clk); #1;
         if (acc) i++;
      end
      wb_valid = 1'b0; dstE = 4'hF; dstM = 4'hF;
      chk("stream accepted", i, 8);
      chk("stream writes", w, 16);
      chk("stream stalled", saw_stall, 1);
      @(negedge clk);
      chk("stream empty", empty, 1);

      // Reset with 3 entries queued
      req(4'd1, 64'h1, 4'd2, 64'h2);
      req(4'd3, 64'h3, 4'd4, 64'h4);
      @(negedge clk);
      chk("rst3 count", count, 3);
      chk("rst3 ready", wb_ready, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst3 count0", count, 0);
      chk("rst3 rf_we", rf_we, 0);
      chk("rst3 ready", wb_ready, 1);
      wrote = 0;
      repeat (3) begin
         @(negedge clk);
         if (rf_we) wrote = 1;
      end
      chk("rst3 no writes", wrote, 0);

      // Two queued writes to r7: busy holds until the last one drains
      srcB = 4'd7;
      req(4'd6, 64'h66, 4'd7, 64'h1);
      chk("r7 busy a", srcB_busy, 1);
`ifdef RF_ARB_FWD_EN
      chk("r7 fwd valid a", fwdB_valid, 1);
      chk("r7 fwd val a", fwdB_val, 64'h1);
`endif
      req(4'd7, 64'h2, 4'hF, 64'h0);
      @(negedge clk);
      chk("r7 count b", count, 2);
      chk("r7 busy b", srcB_busy, 1);
`ifdef RF_ARB_FWD_EN
      chk("r7 fwd val b", fwdB_val, 64'h2);
`endif
      @(negedge clk);
      chk("r7 count c", count, 1);
      chk("r7 busy c", srcB_busy, 1);
      chk("r7 head val c", rf_val, 64'h2);
`ifdef RF_ARB_FWD_EN
      chk("r7 fwd val c", fwdB_val, 64'h2);
`endif
      @(negedge clk);
      chk("r7 busy d", srcB_busy, 0);
      chk("r7 empty d", empty, 1);
`ifdef RF_ARB_FWD_EN
      chk("r7 fwd valid d", fwdB_valid, 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
